rx_buff_admit: RTL and testbench

- Sits in the MAC/RX clock domain, directly downstream of rx_rd_addr_synch.
- Consumes the synchronized committed host read address and uses it to compute free space in the RX circular buffer.
- For each incoming frame, decides whether to admit it or drop it, and sequences admitted frames into the buffer.
- Publishes a committed write address. A sibling synchronizer returns that address to the host-side domain.

---
 rtl/rx_buff_admit_pkg.sv | 25 ++
 rtl/rx_buff_admit_free_calc.sv | 45 ++++
 rtl/rx_buff_admit.sv | 143 ++++++++++++++
 tb/tb_rx_buff_admit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_buff_admit_pkg.sv
// rx_buff_admit_pkg: shared FSM states, header layout and slot helpers for the RX admit block.
package rx_buff_admit_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, HDR, COMMIT} state_e;

    localparam int BYTES_PER_SLOT = 8;
    localparam int SLOT_SH        = $clog2(BYTES_PER_SLOT);
    localparam int LEN_W          = 14;
    localparam int WORDS_W        = LEN_W + 1 - SLOT_SH;
    localparam int HDR_LEN_MSB    = LEN_W - 1;

    function automatic logic [WORDS_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] s;
        s = {1'b0, len} + (LEN_W+1)'(BYTES_PER_SLOT - 1);
        return s[LEN_W:SLOT_SH];
    endfunction

    function automatic logic [63:0] hdr_word(input logic [LEN_W-1:0] len);
        logic [63:0] h;
        h = '0;
        h[HDR_LEN_MSB:0] = len;
        return h;
    endfunction

endpackage

// File: rtl/rx_buff_admit_free_calc.sv
// rx_buff_free_calc: registers words-needed and the admit verdict when a frame is announced.
module rx_buff_free_calc
    import rx_buff_admit_pkg::*;
#(
    parameter int AW      = 10,
    parameter int MAX_LEN = 9022
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [AW-1:0]      rd_addr,
    input  logic [AW-1:0]      wr_addr,
    output logic [WORDS_W-1:0] words,
    output logic               admit_ok
);

    localparam int CW = WORDS_W + AW + 1;

    logic [WORDS_W-1:0] words_q, words_d;
    logic               ok_q, ok_d;
    logic [AW-1:0]      free;

    // Slot demand is compared at full width so oversized frames never alias into a small slot count.
    always_comb begin
        free    = rd_addr - wr_addr - AW'(1);
        words_d = load ? len_to_words(frame_len) : words_q;
        ok_d    = load ? (frame_len != '0 && 32'(frame_len) <= MAX_LEN &&
                          CW'(len_to_words(frame_len)) + CW'(1) <= CW'(free)) : ok_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            words_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            words_q <= words_d;
            ok_q    <= ok_d;
        end
    end

    assign words    = words_q;
    assign admit_ok = ok_q;

endmodule

// File: rtl/rx_buff_admit.sv
// rx_buff_admit: admits or drops RX frames against free ring space and writes payload then header.
// Optional drop counter built when RX_DROP_CNT_EN is defined.
module rx_buff_admit
    import rx_buff_admit_pkg::*;
#(
    parameter int AW      = 10,
    parameter int MAX_LEN = 9022
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    commited_rd_address,
    input  logic             frame_req,
    input  logic [LEN_W-1:0] frame_len,
    output logic             frame_grant,
    output logic             frame_drop,
    input  logic             data_valid,
    input  logic [63:0]      data,
    output logic             data_ready,
    output logic             buf_wr_en,
    output logic [AW-1:0]    buf_wr_addr,
    output logic [63:0]      buf_wr_data,
    output logic [AW-1:0]    commited_wr_address,
    output logic [31:0]      drop_count
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [AW-1:0]      start_q, start_d, wr_ptr_q, wr_ptr_d, cwa_q, cwa_d;
    logic [WORDS_W-1:0] cnt_q, cnt_d, words;
    logic               grant_q, grant_d, drop_q, drop_d, admit_ok, load;

    assign load = state_q == IDLE && frame_req;

    rx_buff_free_calc #(.AW(AW), .MAX_LEN(MAX_LEN)) u_free (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .frame_len (frame_len),
        .rd_addr   (commited_rd_address),
        .wr_addr   (cwa_q),
        .words     (words),
        .admit_ok  (admit_ok)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        start_d     = start_q;
        wr_ptr_d    = wr_ptr_q;
        cwa_d       = cwa_q;
        cnt_d       = cnt_q;
        grant_d     = 1'b0;
        drop_d      = 1'b0;
        data_ready  = 1'b0;
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_wr_data = '0;
        case (state_q)
            IDLE: if (frame_req) begin
                len_d   = frame_len;
                start_d = cwa_q;
                state_d = CHECK;
            end
            CHECK: begin
                grant_d  = admit_ok;
                drop_d   = !admit_ok;
                wr_ptr_d = start_q + AW'(1);
                cnt_d    = '0;
                state_d  = admit_ok ? WRITE : IDLE;
            end
            WRITE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_addr = wr_ptr_q;
                    buf_wr_data = data;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    cnt_d       = cnt_q + WORDS_W'(1);
                    state_d     = cnt_q == words - WORDS_W'(1) ? HDR : WRITE;
                end
            end
            // Header goes in last so the host never sees a length ahead of its payload.
            HDR: begin
                buf_wr_en   = 1'b1;
                buf_wr_addr = start_q;
                buf_wr_data = hdr_word(len_q);
                state_d     = COMMIT;
            end
            COMMIT: begin
                cwa_d   = start_q + AW'(words) + AW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            start_q  <= '0;
            wr_ptr_q <= '0;
            cwa_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            start_q  <= start_d;
            wr_ptr_q <= wr_ptr_d;
            cwa_q    <= cwa_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            drop_q   <= drop_d;
        end
    end

    assign frame_grant         = grant_q;
    assign frame_drop          = drop_q;
    assign commited_wr_address = cwa_q;

`ifdef RX_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_d && drop_cnt_q != '1 ? drop_cnt_q + 32'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_rx_buff_admit.sv
// tb_rx_buff_admit: directed self-checking bench for rx_buff_admit.
module tb_rx_buff_admit;

    localparam int AW = 10;
`ifdef RX_DROP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] rd = '0;
    logic          frame_req = 1'b0;
    logic [13:0]   frame_len = '0;
    logic          data_valid = 1'b0;
    logic [63:0]   data = '0;
    logic          frame_grant, frame_drop, data_ready, buf_wr_en;
    logic [AW-1:0] buf_wr_addr, commited_wr_address;
    logic [63:0]   buf_wr_data;
    logic [31:0]   drop_count;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] wa[$];
    logic [63:0]   wd[$];
    int            resp;
    logic          granted;
    logic [AW-1:0] mid_cwa;

    rx_buff_admit #(.AW(AW), .MAX_LEN(9022)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .commited_rd_address (rd),
        .frame_req           (frame_req),
        .frame_len           (frame_len),
        .frame_grant         (frame_grant),
        .frame_drop          (frame_drop),
        .data_valid          (data_valid),
        .data                (data),
        .data_ready          (data_ready),
        .buf_wr_en           (buf_wr_en),
        .buf_wr_addr         (buf_wr_addr),
        .buf_wr_data         (buf_wr_data),
        .commited_wr_address (commited_wr_address),
        .drop_count          (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (buf_wr_en) begin
            wa.push_back(buf_wr_addr);
            wd.push_back(buf_wr_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pat(input int i);
        return {32'hD0D0D0D0, i[31:0]};
    endfunction

    function automatic logic [31:0] exp_drops(input int n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic send_frame(input logic [13:0] len, input logic noise, input int gap_at,
                              input int gap_n, input int stop_at);
        int n;
        wa.delete();
        wd.delete();
        @(posedge clk); #1;
        frame_req = 1'b1; frame_len = len; data_valid = noise; data = 64'hBAD0;
        @(posedge clk); #1;
        frame_req = 1'b0; frame_len = '0;
        resp = 1;
        while (!frame_grant && !frame_drop && resp < 10) begin
            @(posedge clk); #1;
            resp++;
        end
        granted = frame_grant;
        data_valid = 1'b0;
        if (!granted) begin
            repeat (2) @(posedge clk);
            #1;
            return;
        end
        n = (int'(len) + 7) / 8;
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) begin
                data_valid = 1'b0;
                return;
            end
            if (i == gap_at) begin
                data_valid = 1'b0;
                repeat (gap_n) @(posedge clk);
                #1;
            end
            data_valid = 1'b1; data = pat(i);
            @(posedge clk); #1;
        end
        data_valid = 1'b0; data = '0;
        mid_cwa = commited_wr_address;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
        checks++; if (frame_grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", frame_grant); end
        checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", frame_drop); end
        checks++; if (buf_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", buf_wr_en); end
        checks++; if (commited_wr_address !== '0) begin failures++; $display("FAIL reset_cwa got=%0d exp=0", commited_wr_address); end
        checks++; if (drop_count !== 32'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_empty;
        rd = 10'd0;
        send_frame(14'd64, 1'b0, -1, 0, -1);
        checks++; if (resp != 2) begin failures++; $display("FAIL empty_latency got=%0d exp=2", resp); end
        checks++; if (granted !== 1'b1) begin failures++; $display("FAIL empty_grant got=%b exp=1", granted); end
        checks++; if (wa.size() != 9) begin failures++; $display("FAIL empty_nwrites got=%0d exp=9", wa.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (wa[i] !== 10'(i + 1) || wd[i] !== pat(i)) begin
                failures++; $display("FAIL empty_data[%0d] got=%0d/%h exp=%0d/%h", i, wa[i], wd[i], i + 1, pat(i));
            end
        end
        checks++; if (wa[8] !== 10'd0 || wd[8] !== 64'd64) begin failures++; $display("FAIL empty_hdr got=%0d/%0d exp=0/64", wa[8], wd[8]); end
        checks++; if (commited_wr_address !== 10'd9) begin failures++; $display("FAIL empty_commit got=%0d exp=9", commited_wr_address); end
    endtask

    task automatic test_fill;
        send_frame(14'd8040, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b1) begin failures++; $display("FAIL fill_grant got=%b exp=1", granted); end
        checks++; if (wa.size() != 1006) begin failures++; $display("FAIL fill_nwrites got=%0d exp=1006", wa.size()); end
        checks++; if (wa[0] !== 10'd10 || wa[1004] !== 10'd1014) begin failures++; $display("FAIL fill_span got=%0d..%0d exp=10..1014", wa[0], wa[1004]); end
        checks++; if (wa[1005] !== 10'd9 || wd[1005] !== 64'd8040) begin failures++; $display("FAIL fill_hdr got=%0d/%0d exp=9/8040", wa[1005], wd[1005]); end
        checks++; if (commited_wr_address !== 10'd1015) begin failures++; $display("FAIL fill_commit got=%0d exp=1015", commited_wr_address); end
    endtask

    task automatic test_space_boundary;
        send_frame(14'd64, 1'b1, -1, 0, -1);
        checks++; if (resp != 2 || granted !== 1'b0) begin failures++; $display("FAIL short_drop got=resp%0d/grant%b exp=resp2/grant0", resp, granted); end
        checks++; if (wa.size() != 0) begin failures++; $display("FAIL short_nowrites got=%0d exp=0", wa.size()); end
        checks++; if (commited_wr_address !== 10'd1015) begin failures++; $display("FAIL short_cwa got=%0d exp=1015", commited_wr_address); end
        checks++; if (drop_count !== exp_drops(1)) begin failures++; $display("FAIL short_drop_count got=%0d exp=%0d", drop_count, exp_drops(1)); end
        send_frame(14'd56, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b1) begin failures++; $display("FAIL exact_grant got=%b exp=1", granted); end
        checks++; if (wa.size() != 8) begin failures++; $display("FAIL exact_nwrites got=%0d exp=8", wa.size()); end
        checks++; if (wa[0] !== 10'd1016 || wa[6] !== 10'd1022 || wa[7] !== 10'd1015) begin
            failures++; $display("FAIL exact_addrs got=%0d,%0d,%0d exp=1016,1022,1015", wa[0], wa[6], wa[7]);
        end
        checks++; if (commited_wr_address !== 10'd1023) begin failures++; $display("FAIL exact_commit got=%0d exp=1023", commited_wr_address); end
        send_frame(14'd8, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b0 || resp != 2) begin failures++; $display("FAIL full_drop got=resp%0d/grant%b exp=resp2/grant0", resp, granted); end
        checks++; if (drop_count !== exp_drops(2)) begin failures++; $display("FAIL full_drop_count got=%0d exp=%0d", drop_count, exp_drops(2)); end
    endtask

    task automatic test_wrap;
        int exp_a[8] = '{1021, 1022, 1023, 0, 1, 2, 3, 4};
        rd = 10'd1023;
        send_frame(14'd8160, 1'b0, -1, 0, -1);
        checks++; if (wa.size() != 1021 || wa[0] !== 10'd0 || wa[1020] !== 10'd1023) begin
            failures++; $display("FAIL wrap_prep got=n%0d first%0d hdr%0d exp=n1021 first0 hdr1023", wa.size(), wa[0], wa[1020]);
        end
        checks++; if (commited_wr_address !== 10'd1020) begin failures++; $display("FAIL wrap_prep_commit got=%0d exp=1020", commited_wr_address); end
        rd = 10'd500;
        send_frame(14'd64, 1'b0, -1, 0, -1);
        checks++; if (wa.size() != 9) begin failures++; $display("FAIL wrap_nwrites got=%0d exp=9", wa.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (wa[i] !== 10'(exp_a[i])) begin failures++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, wa[i], exp_a[i]); end
        end
        checks++; if (wa[8] !== 10'd1020 || wd[8] !== 64'd64) begin failures++; $display("FAIL wrap_hdr got=%0d/%0d exp=1020/64", wa[8], wd[8]); end
        checks++; if (commited_wr_address !== 10'd5) begin failures++; $display("FAIL wrap_commit got=%0d exp=5", commited_wr_address); end
    endtask

    task automatic test_illegal;
        send_frame(14'd0, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b0 || resp != 2 || wa.size() != 0) begin failures++; $display("FAIL len0_drop got=grant%b resp%0d n%0d exp=grant0 resp2 n0", granted, resp, wa.size()); end
        send_frame(14'd9023, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b0 || resp != 2 || wa.size() != 0) begin failures++; $display("FAIL len9023_drop got=grant%b resp%0d n%0d exp=grant0 resp2 n0", granted, resp, wa.size()); end
        checks++; if (commited_wr_address !== 10'd5) begin failures++; $display("FAIL illegal_cwa got=%0d exp=5", commited_wr_address); end
        checks++; if (drop_count !== exp_drops(4)) begin failures++; $display("FAIL illegal_drop_count got=%0d exp=%0d", drop_count, exp_drops(4)); end
    endtask

    task automatic test_gaps;
        send_frame(14'd32, 1'b0, 2, 3, -1);
        checks++; if (granted !== 1'b1) begin failures++; $display("FAIL gap_grant got=%b exp=1", granted); end
        checks++; if (wa.size() != 5) begin failures++; $display("FAIL gap_nwrites got=%0d exp=5", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wa[i] !== 10'(6 + i) || wd[i] !== pat(i)) begin
                failures++; $display("FAIL gap_data[%0d] got=%0d/%h exp=%0d/%h", i, wa[i], wd[i], 6 + i, pat(i));
            end
        end
        checks++; if (wa[4] !== 10'd5 || wd[4] !== 64'd32) begin failures++; $display("FAIL gap_hdr got=%0d/%0d exp=5/32", wa[4], wd[4]); end
        checks++; if (mid_cwa !== 10'd5) begin failures++; $display("FAIL gap_early_commit got=%0d exp=5", mid_cwa); end
        checks++; if (commited_wr_address !== 10'd10) begin failures++; $display("FAIL gap_commit got=%0d exp=10", commited_wr_address); end
    endtask

    task automatic test_mid_reset;
        send_frame(14'd64, 1'b0, -1, 0, 3);
        checks++; if (granted !== 1'b1 || wa.size() != 3) begin failures++; $display("FAIL midrst_partial got=grant%b n%0d exp=grant1 n3", granted, wa.size()); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (data_ready !== 1'b0 || buf_wr_en !== 1'b0 || frame_grant !== 1'b0 || frame_drop !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got=rdy%b en%b g%b d%b exp=0000", data_ready, buf_wr_en, frame_grant, frame_drop);
        end
        checks++; if (commited_wr_address !== '0 || drop_count !== 32'd0) begin
            failures++; $display("FAIL midrst_regs got=cwa%0d cnt%0d exp=0/0", commited_wr_address, drop_count);
        end
        reset_n = 1'b1;
        rd = 10'd0;
        send_frame(14'd8, 1'b0, -1, 0, -1);
        checks++; if (granted !== 1'b1 || wa.size() != 2) begin failures++; $display("FAIL midrst_next got=grant%b n%0d exp=grant1 n2", granted, wa.size()); end
        checks++; if (wa[0] !== 10'd1 || wa[1] !== 10'd0 || wd[1] !== 64'd8) begin
            failures++; $display("FAIL midrst_addrs got=%0d,%0d/%0d exp=1,0/8", wa[0], wa[1], wd[1]);
        end
        checks++; if (commited_wr_address !== 10'd2) begin failures++; $display("FAIL midrst_commit got=%0d exp=2", commited_wr_address); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_fill();
        test_space_boundary();
        test_wrap();
        test_illegal();
        test_gaps();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
